uart_loader: RTL and testbench
==============================

UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1C09_0000, meaning the byte address of the first loaded word.
REQ-003 SHALL have parameter MAX_WORDS, default 16384, meaning the maximum number of words written.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port rx, input, 1, the UART serial line (8N1, LSB first), asynchronous to clk and idle high.
REQ-007 SHALL have port uart_data, output, 32, the assembled word for memory port B.
REQ-008 SHALL have port uart_addr, output, 32, the byte address of uart_data.
REQ-009 SHALL have port uart_we, output, 1, a one-cycle pulse marking a new valid uart_data/uart_addr pair.
REQ-010 SHALL have port uart_done, output, 1, set when the load is complete; holds the CPU in reset while low.
REQ-011 SHALL have port frame_err, output, 1, a sticky flag for a framing error seen.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use.
REQ-013 Receiver FSM SHALL have states RX_IDLE, RX_START, RX_DATA and RX_STOP.
REQ-014 RX_IDLE SHALL move to RX_START on a synchronized falling edge (1->0).
REQ-015 RX_START SHALL sample at CLKS_PER_BIT/2; if the line is low, go to RX_DATA, else treat it as a glitch and return to RX_IDLE.
REQ-016 RX_DATA SHALL sample 8 bits, each CLKS_PER_BIT apart, at mid-bit, shifting LSB first.
REQ-017 RX_STOP SHALL sample the stop bit at mid-bit; if high, emit a 1-cycle byte_valid; if low, set frame_err, drop the byte, and not emit byte_valid; then return to RX_IDLE.
REQ-018 Loader FSM SHALL have states LD_LEN, LD_WORD and LD_DONE.
REQ-019 LD_LEN SHALL collect 4 bytes as a little-endian 32-bit count N.
REQ-020 After the 4th length byte, LD_LEN SHALL load the target count as min(N, MAX_WORDS): to LD_DONE if the count is 0, else to LD_WORD.
REQ-021 LD_WORD SHALL assemble each 4 bytes little-endian (first byte to bits [7:0]).
REQ-022 On the 4th byte of a word, uart_data and uart_addr SHALL update on the same clk edge, and uart_we SHALL pulse for 1 cycle on that edge.
REQ-023 The written word SHALL be visible on uart_data one cycle after the 4th byte_valid.
REQ-024 The first word SHALL have uart_addr = BASE_ADDR; the address SHALL increment by 4 per subsequent word and wrap modulo 2^32.
REQ-025 uart_data and uart_addr SHALL hold their values between writes (memory port B writes continuously while uart_done=0).
REQ-026 The loader SHALL go to LD_DONE on the edge that writes the last counted word; uart_done SHALL go high on the same edge as that word's uart_we.
REQ-027 In LD_DONE, uart_done SHALL stay 1 until reset, all further bytes SHALL be ignored, uart_we SHALL stay 0, and uart_data/uart_addr SHALL be frozen.
REQ-028 Length N > MAX_WORDS: the loader SHALL write exactly MAX_WORDS words, then set done; later bytes SHALL be ignored.
REQ-029 A dropped (framing-error) byte SHALL NOT advance the byte counter; byte alignment is the host's responsibility.
REQ-030 Partial-word byte counter SHALL be 2 bits; word counter SHALL be wide enough for MAX_WORDS.

Reset
REQ-031 rst_n low SHALL immediately clear all outputs: uart_data=0, uart_addr=BASE_ADDR, uart_we=0, uart_done=0, frame_err=0.
REQ-032 rst_n low SHALL set receiver to RX_IDLE, loader to LD_LEN, and all counters and shift registers to 0.
REQ-033 Reset mid-frame or mid-word SHALL discard partial data; after release, the loader SHALL wait for a new length header.
REQ-034 Synchronizer flops SHALL reset to 1 (idle) so no false start bit occurs.

Verification (bench CLKS_PER_BIT=16, BASE_ADDR=32'h1C09_0000)
REQ-035 Send bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 -> uart_we pulses twice: (1C090000, 00000013) then (1C090004, 0000006F); uart_done rises with the 2nd pulse.
REQ-036 Send 00 00 00 00 -> uart_done=1 with no uart_we pulse; uart_addr=1C090000.
REQ-037 Send a byte with stop bit 0, then a valid header → frame_err=1 stays set; the bad byte is not counted; the load proceeds on the valid bytes.
REQ-038 A 4-cycle low glitch on rx while idle -> no byte_valid, no state change.
REQ-039 Assert rst_n low after 2 bytes of a word -> outputs are at reset values; a full resend loads correctly from 1C090000.
REQ-040 With MAX_WORDS=2, send N=3 and 3 words -> exactly 2 uart_we pulses; the 3rd word is ignored; uart_done=1.

Source files
------------

// File: rtl/uart_loader.sv
// -----------------------------------------------------------------------------
// uart_loader
// Boot loader that receives a program image over a UART line and streams it
// into memory port B as 32-bit words.
//
// Image format on the wire (8N1, LSB first):
//   4 bytes  little-endian word count N
//   N words  each sent as 4 bytes, little-endian
// At most MAX_WORDS words are written; anything after the last counted word
// is ignored. uart_done holds the CPU in reset until the load completes.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         UART serial input, asynchronous to clk, idle high
//   uart_data  assembled word for memory port B
//   uart_addr  byte address of uart_data
//   uart_we    one-cycle pulse per new uart_data/uart_addr pair
//   uart_done  high once the load is complete (sticky until reset)
//   frame_err  sticky flag, set when a stop bit was sampled low
//
// Receiver FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a 1->0 edge
//   RX_START | half-bit wait, confirm the start bit is still low
//   RX_DATA  | sample 8 data bits at mid-bit, LSB first
//   RX_STOP  | sample the stop bit, emit byte or flag a framing error
//
// Loader FSM
//   state    | meaning
//   LD_LEN   | collecting the 4-byte word count
//   LD_WORD  | collecting data words and writing them out
//   LD_DONE  | load finished, all further bytes ignored
// -----------------------------------------------------------------------------
module uart_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter logic [31:0] BASE_ADDR    = 32'h1C09_0000,
   parameter int unsigned MAX_WORDS    = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   output logic [31:0] uart_data,
   output logic [31:0] uart_addr,
   output logic        uart_we,
   output logic        uart_done,
   output logic        frame_err
);

   localparam int unsigned TW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned WCW = $clog2(MAX_WORDS + 1);

   localparam logic [TW-1:0]  FULL_LOAD   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]  HALF_LOAD   = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0]    MAX_WORDS_W = 32'(MAX_WORDS);
   localparam logic [WCW-1:0] MAX_WORDS_C = WCW'(MAX_WORDS);

   // ---------------------------------------------------------------------------
   // rx synchronizer plus one extra stage for falling-edge detection.
   // All stages reset to the idle level so reset release cannot fake a start.
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_sync;
   logic rx_prev;
   logic start_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign start_edge = rx_prev & ~rx_sync;

   // ---------------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   rx_state_t       rx_state;
   rx_state_t       rx_next;
   logic [TW-1:0]   bit_timer;
   logic            bit_tc;
   logic [2:0]      bit_cnt;
   logic [7:0]      rx_shift;
   logic            byte_valid;

   logic            tmr_load_half;
   logic            tmr_load_full;
   logic            shift_en;
   logic            stop_ok;
   logic            stop_bad;

   assign bit_tc = (bit_timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
      end else begin
         rx_state <= rx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: begin
            if (start_edge) rx_next = RX_START;
         end
         RX_START: begin
            // A line that is high again at half-bit was only a glitch.
            if (bit_tc) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (bit_tc && (bit_cnt == 3'd7)) rx_next = RX_STOP;
         end
         RX_STOP: begin
            if (bit_tc) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      tmr_load_half = 1'b0;
      tmr_load_full = 1'b0;
      shift_en      = 1'b0;
      stop_ok       = 1'b0;
      stop_bad      = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            tmr_load_half = start_edge;
         end
         RX_START: begin
            tmr_load_full = bit_tc & ~rx_sync;
         end
         RX_DATA: begin
            // Reload on every data sample; the last reload times the stop bit.
            tmr_load_full = bit_tc;
            shift_en      = bit_tc;
         end
         RX_STOP: begin
            stop_ok  = bit_tc & rx_sync;
            stop_bad = bit_tc & ~rx_sync;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_timer  <= '0;
         bit_cnt    <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (tmr_load_half) begin
            bit_timer <= HALF_LOAD;
         end else if (tmr_load_full) begin
            bit_timer <= FULL_LOAD;
         end else if (!bit_tc) begin
            bit_timer <= bit_timer - 1'b1;
         end

         if (tmr_load_half) begin
            bit_cnt <= '0;
         end else if (shift_en) begin
            bit_cnt <= bit_cnt + 3'd1;
         end

         if (shift_en) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
         end

         byte_valid <= stop_ok;

         if (stop_bad) begin
            frame_err <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Loader
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      LD_LEN  = 2'd0,
      LD_WORD = 2'd1,
      LD_DONE = 2'd2
   } ld_state_t;

   ld_state_t       ld_state;
   ld_state_t       ld_next;
   logic [1:0]      byte_cnt;
   logic [31:0]     asm_reg;
   logic [31:0]     asm_full;
   logic [WCW-1:0]  words_left;
   logic [WCW-1:0]  target_cnt;
   logic [31:0]     next_addr;
   logic            last_byte;

   logic            byte_take;
   logic            len_load;
   logic            word_wr;

   // Bytes shift in from the top, so after four of them the first byte
   // received sits in bits [7:0].
   assign asm_full   = {rx_shift, asm_reg[31:8]};
   assign last_byte  = byte_valid && (byte_cnt == 2'd3);
   assign target_cnt = (asm_full > MAX_WORDS_W) ? MAX_WORDS_C : asm_full[WCW-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_state <= LD_LEN;
      end else begin
         ld_state <= ld_next;
      end
   end

   always_comb begin
      ld_next = ld_state;
      case (ld_state)
         LD_LEN: begin
            if (last_byte) ld_next = (target_cnt == '0) ? LD_DONE : LD_WORD;
         end
         LD_WORD: begin
            // Leave on the same edge that writes the last counted word.
            if (last_byte && (words_left == WCW'(1))) ld_next = LD_DONE;
         end
         LD_DONE: begin
            ld_next = LD_DONE;
         end
         default: ld_next = LD_LEN;
      endcase
   end

   always_comb begin
      uart_done = (ld_state == LD_DONE);
      byte_take = byte_valid && (ld_state != LD_DONE);
      len_load  = last_byte && (ld_state == LD_LEN);
      word_wr   = last_byte && (ld_state == LD_WORD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt   <= '0;
         asm_reg    <= '0;
         words_left <= '0;
         next_addr  <= BASE_ADDR;
         uart_data  <= '0;
         uart_addr  <= BASE_ADDR;
         uart_we    <= 1'b0;
      end else begin
         if (byte_take) begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_reg  <= asm_full;
         end

         if (len_load) begin
            words_left <= target_cnt;
         end else if (word_wr) begin
            words_left <= words_left - WCW'(1);
         end

         // Data and address only move on a write so memory port B sees a
         // stable pair between writes.
         if (word_wr) begin
            uart_data <= asm_full;
            uart_addr <= next_addr;
            next_addr <= next_addr + 32'd4;
         end

         uart_we <= word_wr;
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
module tb_uart_loader;

   localparam int unsigned CPB   = 16;
   localparam logic [31:0] BASE  = 32'h1C09_0000;
   localparam int unsigned MAXW  = 16384;
   localparam int unsigned MAXW2 = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        rx2 = 1'b1;

   logic [31:0] uart_data, uart_addr, uart_data2, uart_addr2;
   logic        uart_we, uart_done, frame_err;
   logic        uart_we2, uart_done2, frame_err2;

   uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .uart_data(uart_data), .uart_addr(uart_addr), .uart_we(uart_we),
      .uart_done(uart_done), .frame_err(frame_err)
   );

   uart_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(MAXW2)) dut2 (
      .clk(clk), .rst_n(rst_n), .rx(rx2),
      .uart_data(uart_data2), .uart_addr(uart_addr2), .uart_we(uart_we2),
      .uart_done(uart_done2), .frame_err(frame_err2)
   );

   always #5 clk = ~clk;

   int n_asserts = 0;
   int n_fails   = 0;

   // Observed writes, captured away from the active edge.
   logic [31:0] q_addr[$], q_data[$], q2_addr[$], q2_data[$];
   bit          q_done[$], q2_done[$];

   always @(negedge clk) begin
      if (uart_we) begin
         q_addr.push_back(uart_addr);
         q_data.push_back(uart_data);
         q_done.push_back(uart_done);
      end
      if (uart_we2) begin
         q2_addr.push_back(uart_addr2);
         q2_data.push_back(uart_data2);
         q2_done.push_back(uart_done2);
      end
   end

   // Reference: expected writes derived from the image format.
   logic [31:0] sent_words[$];
   logic [31:0] exp_addr[$], exp_data[$];
   bit          exp_done[$];
   bit          exp_final_done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx = v;
      else rx2 = v;
   endtask

   task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit = 1'b1);
      @(negedge clk);
      set_line(sel, 1'b0);
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, b[i]);
         repeat (CPB) @(negedge clk);
      end
      set_line(sel, stop_bit);
      repeat (CPB) @(negedge clk);
      set_line(sel, 1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic send_word(input int sel, input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8]);
   endtask

   task automatic run_load(input int sel, input logic [31:0] n);
      send_word(sel, n);
      foreach (sent_words[i]) send_word(sel, sent_words[i]);
      repeat (8) @(negedge clk);
   endtask

   task automatic model_load(input logic [31:0] n, input int unsigned maxw);
      int unsigned target;
      target = (n > maxw) ? maxw : n;
      exp_addr.delete();
      exp_data.delete();
      exp_done.delete();
      for (int i = 0; i < sent_words.size() && i < int'(target); i++) begin
         exp_addr.push_back(BASE + 32'(4 * i));
         exp_data.push_back(sent_words[i]);
         exp_done.push_back(i == int'(target) - 1);
      end
      exp_final_done = (sent_words.size() >= int'(target));
   endtask

   task automatic check_writes(input int sel, input string tag);
      int cnt;
      cnt = (sel == 0) ? q_addr.size() : q2_addr.size();
      chk({tag, "_count"}, 32'(cnt), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < cnt; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), (sel == 0) ? q_addr[i] : q2_addr[i], exp_addr[i]);
         chk($sformatf("%s_data%0d", tag, i), (sel == 0) ? q_data[i] : q2_data[i], exp_data[i]);
         chk($sformatf("%s_done%0d", tag, i), 32'((sel == 0) ? q_done[i] : q2_done[i]),
             32'(exp_done[i]));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"}, uart_data, 32'h0);
      chk({tag, "_addr"}, uart_addr, BASE);
      chk({tag, "_we"}, 32'(uart_we), 32'h0);
      chk({tag, "_done"}, 32'(uart_done), 32'h0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rx    = 1'b1;
      rx2   = 1'b1;
      repeat (3) @(negedge clk);
      q_addr.delete(); q_data.delete(); q_done.delete();
      q2_addr.delete(); q2_data.delete(); q2_done.delete();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [31:0] n;
      int          nsent;

      // Reset values while rst_n is held low.
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Two-word load.
      sent_words = '{32'h0000_0013, 32'h0000_006F};
      run_load(0, 32'd2);
      model_load(32'd2, MAXW);
      check_writes(0, "two");
      chk("two_done", 32'(uart_done), 32'h1);
      chk("two_hold_addr", uart_addr, 32'h1C09_0004);
      chk("two_hold_data", uart_data, 32'h0000_006F);
      chk("two_ferr", 32'(frame_err), 32'h0);

      // Zero-length image.
      apply_reset();
      sent_words.delete();
      run_load(0, 32'd0);
      chk("zero_done", 32'(uart_done), 32'h1);
      chk("zero_count", 32'(q_addr.size()), 32'h0);
      chk("zero_addr", uart_addr, BASE);

      // Short glitch while idle, then a framing error, then a valid load.
      apply_reset();
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_done", 32'(uart_done), 32'h0);
      chk("glitch_ferr", 32'(frame_err), 32'h0);
      send_byte(0, 8'hA5, 1'b0);
      chk("ferr_set", 32'(frame_err), 32'h1);
      sent_words = '{32'hDEAD_BEEF};
      run_load(0, 32'd1);
      model_load(32'd1, MAXW);
      check_writes(0, "ferr_load");
      chk("ferr_load_done", 32'(uart_done), 32'h1);
      chk("ferr_sticky", 32'(frame_err), 32'h1);

      // Reset mid-word and mid-frame, then a full resend.
      apply_reset();
      send_word(0, 32'd1);
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB + 5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      chk("midrst_count", 32'(q_addr.size()), 32'h0);
      apply_reset();
      sent_words = '{32'hCAFE_F00D};
      run_load(0, 32'd1);
      model_load(32'd1, MAXW);
      check_writes(0, "resend");
      chk("resend_done", 32'(uart_done), 32'h1);

      // Length above MAX_WORDS on the small instance.
      apply_reset();
      sent_words = '{$urandom, $urandom, $urandom};
      run_load(1, 32'd3);
      model_load(32'd3, MAXW2);
      check_writes(1, "cap");
      chk("cap_done", 32'(uart_done2), 32'h1);
      chk("cap_frozen_data", uart_data2, sent_words[1]);
      chk("cap_frozen_addr", uart_addr2, BASE + 32'd4);

      // Randomized loads, some short of N, some with trailing extra words.
      for (int it = 0; it < 6; it++) begin
         apply_reset();
         n     = 32'($urandom_range(0, 5));
         nsent = $urandom_range(0, int'(n) + 1);
         sent_words.delete();
         for (int k = 0; k < nsent; k++) sent_words.push_back($urandom);
         run_load(0, n);
         model_load(n, MAXW);
         check_writes(0, $sformatf("rnd%0d", it));
         chk($sformatf("rnd%0d_done", it), 32'(uart_done), 32'(exp_final_done));
         chk($sformatf("rnd%0d_ferr", it), 32'(frame_err), 32'h0);
         if (exp_data.size() > 0) begin
            chk($sformatf("rnd%0d_hold", it), uart_data, exp_data[exp_data.size() - 1]);
         end else begin
            chk($sformatf("rnd%0d_hold", it), uart_addr, BASE);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
